// File: rtl/satalnk_txcrc_if.sv
// Dword stream bundle for the link TX CRC stage: upstream FIS input,
// downstream framed output, and the over-length flag.
interface satalnk_txcrc_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_crc;
  logic        o_err;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_crc, o_err
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_crc, o_err
  );
endinterface

// File: rtl/satalnk_txcrc.sv
// SATA link TX stage: forwards FIS dwords, appends the frame CRC dword, flags
// over-length frames. Define SATA_TXCRC_SCRAMBLE_EN to scramble the output.
module satalnk_txcrc #(
  parameter int MAX_DWORDS   = 2049,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic i_phy_clk,
  input  logic i_phy_reset_n,
  satalnk_txcrc_if.slave bus
);
  localparam int          CW       = $clog2(MAX_DWORDS + 2);
  localparam logic [CW-1:0] CNT_ERR = CW'(MAX_DWORDS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_DWORDS + 1);
  localparam logic [31:0] CRC_SEED = 32'h52325032;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  typedef enum logic {S_DATA, S_CRC_PEND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   crc_q, crc_nxt;
  logic          vld_q, last_q, crcf_q, err_q;
  logic [31:0]   data_q;
  logic [31:0]   scr_w;
  logic          load, acc, crc_load;

  // Bit 31 enters first; the whole dword folds in within one cycle.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  assign load        = !vld_q || bus.i_ready;
  assign bus.o_ready = load && (state_q == S_DATA);
  assign acc         = bus.i_valid && bus.o_ready;
  assign crc_load    = load && (state_q == S_CRC_PEND);
  assign crc_nxt     = crc_step(crc_q, bus.i_data);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DATA:     if (acc && bus.i_last) state_d = S_CRC_PEND;
      S_CRC_PEND: if (load) state_d = S_DATA;
      default:    state_d = S_DATA;
    endcase
  end

  always_ff @(posedge i_phy_clk) begin
    if (!i_phy_reset_n) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      crc_q   <= CRC_SEED;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      crcf_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // cnt_q holds dwords already taken, so this acceptance is dword cnt_q+1.
      err_q   <= acc && (cnt_q == CNT_ERR);
      if (acc) begin
        vld_q  <= 1'b1;
        data_q <= bus.i_data ^ scr_w;
        last_q <= 1'b0;
        crcf_q <= 1'b0;
        crc_q  <= crc_nxt;
        if (!bus.i_last && cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end else if (crc_load) begin
        vld_q  <= 1'b1;
        data_q <= crc_q ^ scr_w;
        last_q <= 1'b1;
        crcf_q <= 1'b1;
        crc_q  <= CRC_SEED;
        cnt_q  <= '0;
      end else if (bus.i_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

`ifdef SATA_TXCRC_SCRAMBLE_EN
  logic [15:0] scr_q;
  logic [47:0] scr_nxt;

  // Galois LFSR x^16+x^15+x^13+x^4+1; keystream bit i is emitted at step i.
  function automatic logic [47:0] scr_run(input logic [15:0] s);
    logic [15:0] c;
    logic [31:0] w;
    c = s;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = c[15];
      c = {c[14:0], 1'b0} ^ (c[15] ? 16'hA011 : 16'h0000);
    end
    return {c, w};
  endfunction

  assign scr_nxt = scr_run(scr_q);
  assign scr_w   = scr_nxt[31:0];

  always_ff @(posedge i_phy_clk) begin
    if (!i_phy_reset_n)  scr_q <= 16'hFFFF;
    else if (crc_load)   scr_q <= 16'hFFFF;
    else if (acc)        scr_q <= scr_nxt[47:32];
  end
`else
  assign scr_w = '0;
`endif

  assign bus.o_valid = vld_q;
  assign bus.o_data  = (OPT_LOWPOWER && !vld_q) ? '0 : data_q;
  assign bus.o_last  = (OPT_LOWPOWER && !vld_q) ? 1'b0 : last_q;
  assign bus.o_crc   = crcf_q;
  assign bus.o_err   = err_q;
endmodule

// File: tb/tb_satalnk_txcrc.sv
// Bench for satalnk_txcrc: directed frames against a polynomial-division CRC
// model and a keystream scrambler model, checked on every clock.
module tb_satalnk_txcrc;
  localparam int MAXD = 2049;
  localparam logic [31:0] SEED = 32'h52325032;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  satalnk_txcrc_if bus();

  satalnk_txcrc #(.MAX_DWORDS(MAXD), .OPT_LOWPOWER(1'b0)) dut (
    .i_phy_clk    (clk),
    .i_phy_reset_n(rst_n),
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        c;
  } item_t;

  item_t       exp_q[$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0, err_cyc = -10;
  int          m_cnt = 0, n_out = 0, n_errhi = 0, n_rdylo = 0;
  logic [31:0] m_crc = SEED;
  logic [15:0] m_sctx = 16'hFFFF;
  logic [31:0] last_crc = '0, out_first = '0;
  logic        rst_chk = 1'b0, rand_rdy = 1'b0;
  logic        prev_hold = 1'b0, prev_l = 1'b0, prev_c = 1'b0;
  logic [31:0] prev_d = '0;

  // CRC after one dword: ((crc ^ d) * x^32) mod G over GF(2).
  function automatic logic [31:0] m_step(input logic [31:0] c, input logic [31:0] d);
    logic [63:0] v;
    v = {c ^ d, 32'h0};
    for (int b = 63; b >= 32; b--)
      if (v[b]) v = v ^ ({31'h0, 33'h1_04C11DB7} << (b - 32));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_scr_word(input logic [15:0] s);
    logic [15:0] c;
    logic [31:0] w;
    c = s;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = c[15];
      c = (c << 1) ^ (c[15] ? 16'hA011 : 16'h0);
    end
    return w;
  endfunction

  function automatic logic [15:0] m_scr_adv(input logic [15:0] s);
    logic [15:0] c;
    c = s;
    for (int i = 0; i < 32; i++) c = (c << 1) ^ (c[15] ? 16'hA011 : 16'h0);
    return c;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Single observer of both sides; all signals are settled at the falling edge.
  always @(negedge clk) begin
    logic [31:0] ks;
    item_t it;
    if (!rst_n) begin
      exp_q.delete();
      m_crc = SEED; m_cnt = 0; err_cyc = -10; m_sctx = 16'hFFFF;
      prev_hold = 1'b0; rst_chk = 1'b1;
    end else begin
      if (rst_chk) begin
        check("rst_state", {bus.o_valid, bus.o_last, bus.o_crc, bus.o_err, bus.o_data}, 36'h0);
        rst_chk = 1'b0;
      end
      if (!bus.o_ready) n_rdylo++;
      check("o_err", bus.o_err, (cyc == err_cyc));
      if (bus.o_err) n_errhi++;
      if (prev_hold)
        check("hold", {bus.o_valid, bus.o_data, bus.o_last, bus.o_crc}, {1'b1, prev_d, prev_l, prev_c});
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_d = bus.o_data; prev_l = bus.o_last; prev_c = bus.o_crc;
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", bus.o_data, 32'h0);
        end else begin
          it = exp_q.pop_front();
`ifdef SATA_TXCRC_SCRAMBLE_EN
          ks = m_scr_word(m_sctx);
          m_sctx = it.c ? 16'hFFFF : m_scr_adv(m_sctx);
`else
          ks = 32'h0;
`endif
          check("o_data", bus.o_data, it.d ^ ks);
          check("o_last_crc", {bus.o_last, bus.o_crc}, {it.l, it.c});
          if (it.c) last_crc = bus.o_data ^ ks;
          if (n_out == 0) out_first = bus.o_data;
          n_out++;
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back('{d: bus.i_data, l: 1'b0, c: 1'b0});
        m_crc = m_step(m_crc, bus.i_data);
        m_cnt++;
        if (m_cnt == MAXD + 1) err_cyc = cyc + 1;
        if (bus.i_last) begin
          exp_q.push_back('{d: m_crc, l: 1'b1, c: 1'b1});
          m_crc = SEED; m_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_last = l;
    @(negedge clk);
    while (!bus.o_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.o_ready) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Model pins: crc^d = 1 gives x^32 mod G; crc^d = 2 gives x^33 mod G.
    check("pin_x32", m_step(SEED, SEED ^ 32'h1), 32'h04C11DB7);
    check("pin_x33", m_step(SEED, SEED ^ 32'h2), 32'h09823B6E);
    check("pin_zero", m_step(SEED, SEED), 32'h0);
    check("pin_scr", m_scr_word(16'hFFFF), 32'hC2D2768D);

    // Basic frame, always ready: exactly one stalled input cycle.
    n_rdylo = 0;
    send(32'h00000046, 1'b0); send(32'h12345678, 1'b0); send(32'hDEADBEEF, 1'b1);
    drain();
    check("rdy_low_cycles", n_rdylo, 1);

    // Same frame under random backpressure.
    rand_rdy = 1'b1;
    send(32'h00000046, 1'b0); send(32'h12345678, 1'b0); send(32'hDEADBEEF, 1'b1);
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // One-dword frame followed at once by another frame.
    send(32'h00000034, 1'b1);
    send(32'h00000001, 1'b0); send(32'h00000002, 1'b0); send(32'h00000003, 1'b1);
    drain();

    // Hand-derived CRCs straight off the DUT.
    send(SEED ^ 32'h1, 1'b1); drain();
    check("crc_lit_x32", last_crc, 32'h04C11DB7);
    send(SEED ^ 32'h2, 1'b1); drain();
    check("crc_lit_x33", last_crc, 32'h09823B6E);

    // Over-length frame, then a legal one.
    n_out = 0; n_errhi = 0;
    for (int i = 0; i < MAXD + 1; i++) send(32'hA5000000 + i, (i == MAXD));
    send(32'h11111111, 1'b0); send(32'h22222222, 1'b0); send(32'h33333333, 1'b1);
    drain();
    check("err_pulses", n_errhi, 1);
    check("long_outputs", n_out, MAXD + 1 + 1 + 4);

    // Reset after 5 of 10 dwords; nothing of that frame may follow.
    for (int i = 0; i < 5; i++) send(32'hC0DE0000 + i, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(SEED ^ 32'h1, 1'b0); send(32'h04C11DB7, 1'b1);
    drain();
    check("crc_after_rst", last_crc, 32'h0);

`ifdef SATA_TXCRC_SCRAMBLE_EN
    n_out = 0;
    send(32'h00000000, 1'b1);
    drain();
    check("scr_first", out_first, 32'hC2D2768D);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
